prefetch_queue: RTL and testbench

- Parametrised successor to the single-entry prefetch stage: a 2^AW-entry pull-style prefetch queue between a get/empty source (e.g. a sequential ROM) and a get/empty consumer.
- Adds a programmable consumer hold-off: after popping a word that matches a masked pattern, empty_o is forced high for a programmable number of cycles.
- Sits between memory/sequencer sources and byte-stream consumers.

---
 rtl/prefetch_queue.sv | 100 ++++++++++
 tb/tb_prefetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue: 2^AW-entry pull-style prefetch queue between a get/empty
// source and a get/empty consumer, with a programmable consumer hold-off
// that stalls the consumer for `delay` cycles after a word matching
// (match, mask) is popped.
//
// Optional build macro PREFETCH_QUEUE_BYPASS_EN: when the queue is empty and
// no hold-off is active, the upstream word is presented directly on `out`
// (zero-latency cut-through); a pop in that state consumes the upstream word
// without storing it.
module prefetch_queue #(
    parameter int W  = 8,
    parameter int AW = 2,
    parameter int TW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  in,
    output logic          get_i,
    input  logic          empty_i,
    output logic [W-1:0]  out,
    input  logic          get_o,
    output logic          empty_o,
    input  logic [W-1:0]  match,
    input  logic [W-1:0]  mask,
    input  logic [TW-1:0] delay,
    output logic [AW:0]   level
);

    localparam int          D     = 1 << AW;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [D];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [TW-1:0] hold;

    logic          bypass;
    logic          pop;
    logic          store;
    logic          advance;
    logic          hit;

    // Consumer view, fill strobe and the push/pop decisions for this cycle
    always_comb begin
        bypass = 1'b0;
`ifdef PREFETCH_QUEUE_BYPASS_EN
        bypass = (level == '0) && (hold == '0);
`endif
        out = bypass ? in : mem[head];
        if (reset) begin
            empty_o = 1'b1;
        end else if (bypass) begin
            empty_o = empty_i;
        end else begin
            empty_o = (level == '0) || (hold != '0);
        end
        pop     = get_o & ~empty_o;
        get_i   = ~reset & ~empty_i & ((level != DEPTH) | pop);
        hit     = ((out ^ match) & mask) == '0;
        // A bypassed word is handed straight to the consumer and never stored.
        store   = get_i & ~(bypass & pop);
        advance = pop & ~bypass;
    end

    // Control state: pointers, occupancy and hold-off counter
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
            hold  <= '0;
        end else begin
            if (store) begin
                tail <= tail + 1'b1;
            end
            if (advance) begin
                head <= head + 1'b1;
            end
            if (store && !advance) begin
                level <= level + 1'b1;
            end else if (advance && !store) begin
                level <= level - 1'b1;
            end
            // delay is only looked at on the popping edge; otherwise count down.
            if (pop && hit && (delay != '0)) begin
                hold <= delay;
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end
        end
    end

    // Word storage; data path carries no reset, writes are gated by store
    always_ff @(posedge clock) begin
        if (store) begin
            mem[tail] <= in;
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: table-driven and scoreboard-based bench for
// prefetch_queue. Inputs are driven on the falling edge, outputs sampled
// just after it; a reference queue tracks every stored word and the hold-off
// counter. Also builds with PREFETCH_QUEUE_BYPASS_EN defined.
`timescale 1ns/1ps
module tb_prefetch_queue;

    localparam int W  = 8;
    localparam int AW = 2;
    localparam int TW = 3;
    localparam int D  = 1 << AW;
`ifdef PREFETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic [W-1:0]  in      = '0;
    logic          empty_i = 1'b1;
    logic          get_o   = 1'b0;
    logic [W-1:0]  match   = '0;
    logic [W-1:0]  mask    = '0;
    logic [TW-1:0] delay   = '0;
    logic          get_i;
    logic [W-1:0]  out;
    logic          empty_o;
    logic [AW:0]   level;

    prefetch_queue #(.W(W), .AW(AW), .TW(TW)) dut (
        .clock   (clock),
        .reset   (reset),
        .in      (in),
        .get_i   (get_i),
        .empty_i (empty_i),
        .out     (out),
        .get_o   (get_o),
        .empty_o (empty_o),
        .match   (match),
        .mask    (mask),
        .delay   (delay),
        .level   (level)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    int            cyc_n  = 0;
    logic [W-1:0]  sb [$];
    logic [W-1:0]  src [$];
    int            src_idx = 0;
    bit            pause = 1'b0;
    int            hold_m = 0;
    logic [TW-1:0] delay_nx = '0;
    int            pop_cyc [$];
    logic [W-1:0]  pop_words [$];

    typedef struct {
        bit rst;
        bit go;
        bit gi;
        int lvl;
        bit eo;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc_n);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic cyc(input bit rst, input bit go);
        bit           byp;
        bit           exp_eo;
        bit           exp_gi;
        bit           popv;
        bit           hit;
        logic [W-1:0] word;
        @(negedge clock);
        reset   = rst;
        get_o   = go;
        delay   = delay_nx;
        empty_i = pause || (src_idx >= src.size());
        in      = empty_i ? 8'h00 : src[src_idx];
        #1;
        byp = BYP && !rst && (sb.size() == 0) && (hold_m == 0);
        if (rst) exp_eo = 1'b1;
        else if (byp) exp_eo = empty_i;
        else exp_eo = (sb.size() == 0) || (hold_m != 0);
        popv   = go && !exp_eo;
        exp_gi = !rst && !empty_i && ((sb.size() != D) || popv);
        chk("level", level, sb.size());
        chk("empty_o", empty_o, exp_eo);
        chk("get_i", get_i, exp_gi);
        if (!exp_eo) chk("out", out, byp ? in : sb[0]);
        if (rst) begin
            sb.delete();
            hold_m = 0;
        end else begin
            if (popv) begin
                word = byp ? in : sb.pop_front();
                hit  = ((word ^ match) & mask) == '0;
                pop_cyc.push_back(cyc_n);
                pop_words.push_back(word);
                if (hit && delay != 0) hold_m = int'(delay);
                else if (hold_m > 0) hold_m = hold_m - 1;
            end else if (hold_m > 0) begin
                hold_m = hold_m - 1;
            end
            if (exp_gi && !(byp && popv)) sb.push_back(in);
            if (exp_gi) src_idx++;
        end
        cyc_n++;
    endtask

    task automatic load_hello(input logic [W-1:0] m, input logic [W-1:0] k, input logic [TW-1:0] d);
        src = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        src_idx = 0;
        pop_cyc.delete();
        pop_words.delete();
        match = m;
        mask = k;
        delay_nx = d;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npop;
        // reset / idle then fill without consumer
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 0, !BYP};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 3, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 4, 1'b0};

        repeat (2) @(posedge clock);
        src = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A, 8'h00};
        src_idx = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].rst, tbl[i].go);
            chk("tbl_get_i", get_i, tbl[i].gi);
            chk("tbl_level", level, tbl[i].lvl);
            chk("tbl_empty_o", empty_o, tbl[i].eo);
        end
        chk("fill_pushes", src_idx, 4);
        chk("fill_head", out, 8'h68);

        // streaming from a full queue, then get_o while empty
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b1);
        chk("stream_count", pop_words.size(), 7);
        for (int i = 0; i < pop_words.size() && i < 7; i++) chk("stream_order", pop_words[i], src[i]);
        chk("stream_drained", empty_o, 1'b1);

`ifdef PREFETCH_QUEUE_BYPASS_EN
        src = '{8'hA5};
        src_idx = 0;
        cyc(1'b0, 1'b0);
        chk("bypass_out", out, 8'hA5);
        chk("bypass_empty", empty_o, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
`endif

        // hold-off on 0x48 for 5 cycles; delay changes mid-hold are ignored
        load_hello(8'h48, 8'hFF, 3'd5);
        for (int i = 0; i < 20; i++) begin
            if (pop_cyc.size() == 1) delay_nx = 3'd2;
            cyc(1'b0, 1'b1);
        end
        chk("hold_pops", pop_cyc.size(), 5);
        if (pop_cyc.size() >= 3) begin
            chk("hold_gap", pop_cyc[1] - pop_cyc[0], 6);
            chk("nohold_gap", pop_cyc[2] - pop_cyc[1], 1);
        end

        // delay=0 with a matching word: no hold
        load_hello(8'h48, 8'hFF, 3'd0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1);
        chk("d0_pops", pop_cyc.size(), 5);
        for (int i = 1; i < pop_cyc.size(); i++) chk("d0_gap", pop_cyc[i] - pop_cyc[i-1], 1);

        // mask=0 delay=1: one idle cycle after every pop
        load_hello(8'h00, 8'h00, 3'd1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
        chk("m0_pops", pop_cyc.size(), 5);
        for (int i = 1; i < pop_cyc.size(); i++) chk("m0_gap", pop_cyc[i] - pop_cyc[i-1], 2);

        // reset during hold-off with level 3
        load_hello(8'h48, 8'hFF, 3'd5);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("midrst_level_before", level, 3);
        pause = 1'b1;
        cyc(1'b0, 1'b1);
        chk("midrst_level", level, 0);
        chk("midrst_empty", empty_o, 1'b1);
        pause = 1'b0;
        npop = pop_words.size();
        repeat (3) cyc(1'b0, 1'b1);
        chk("midrst_hold_cleared", pop_words.size() > npop, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
